// File: rtl/alb_nibble_seq.sv
// alb_nibble_seq: runs a 4*NIB-bit op through one 4-bit ALB, nibble by nibble.
// Define ALB_SEQ_ABORT_EN to add the ABORT input that cancels a running op.
module alb_nibble_seq #(
   parameter int NIB = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [1:0]         OP,
   input  logic               CIN,
   input  logic [4*NIB-1:0]   A,
   input  logic [4*NIB-1:0]   B,
`ifdef ALB_SEQ_ABORT_EN
   input  logic               ABORT,
`endif
   output logic               READY,
   output logic               DONE,
   output logic [4*NIB-1:0]   RESULT,
   output logic               C_OUT,
   output logic               V_OUT,
   output logic               N_OUT,
   output logic               Z_OUT,
   output logic [3:0]         MR,
   output logic [3:0]         MS,
   output logic               CI,
   output logic [2:0]         ALB_MI,
   input  logic [3:0]         F_ALB,
   input  logic               CO,
   input  logic               VO,
   input  logic               NO,
   input  logic               ZO
);

   localparam int W  = 4 * NIB;
   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [1:0]      op_reg;
   logic [IW-1:0]   idx;
   logic            carry;
   logic            zacc;
   logic [W-1:0]    work;
   logic [W-1:0]    work_nx;
   logic            last;
   logic            abort;
   logic            unused_no;

   // ALB negative flag equals F_ALB[3]; N_OUT is taken from F_ALB directly
   assign unused_no = NO;

`ifdef ALB_SEQ_ABORT_EN
   assign abort = ABORT;
`else
   assign abort = 1'b0;
`endif

   assign last = (idx == IW'(NIB - 1));

   // work register with the current ALB nibble merged in
   always_comb begin
      work_nx = work;
      work_nx[4*idx +: 4] = F_ALB;
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_n;
   end

   // next state and ALB drive; ALB inputs are quiet outside RUN
   always_comb begin
      state_n = state;
      READY   = 1'b0;
      DONE    = 1'b0;
      MR      = 4'h0;
      MS      = 4'h0;
      CI      = 1'b0;
      ALB_MI  = 3'b000;
      case (state)
         S_IDLE: begin
            READY = 1'b1;
            if (START) state_n = S_RUN;
         end
         S_RUN: begin
            MR     = a_reg[4*idx +: 4];
            MS     = b_reg[4*idx +: 4];
            CI     = carry;
            ALB_MI = {1'b0, op_reg};
            if (abort)     state_n = S_IDLE;
            else if (last) state_n = S_DONE;
         end
         S_DONE: begin
            DONE    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // operand capture, nibble walk and whole-word result/flag commit
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= 2'b00;
         idx    <= '0;
         carry  <= 1'b0;
         zacc   <= 1'b1;
         work   <= '0;
         RESULT <= '0;
         C_OUT  <= 1'b0;
         V_OUT  <= 1'b0;
         N_OUT  <= 1'b0;
         Z_OUT  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  op_reg <= OP;
                  idx    <= '0;
                  carry  <= CIN;
                  zacc   <= 1'b1;
               end
            end
            S_RUN: begin
               if (abort) begin
                  idx   <= '0;
                  carry <= 1'b0;
                  zacc  <= 1'b1;
                  work  <= '0;
               end else begin
                  work  <= work_nx;
                  carry <= CO;
                  zacc  <= zacc & ZO;
                  if (last) begin
                     idx    <= '0;
                     RESULT <= work_nx;
                     C_OUT  <= CO;
                     V_OUT  <= VO;
                     N_OUT  <= F_ALB[3];
                     Z_OUT  <= zacc & ZO;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alb_nibble_seq.md
# alb_nibble_seq

Multi-precision sequencer for the 4-bit ALB. It accepts a wide operation (NIB nibbles) from a requester and runs the ALB once per nibble, LSB first, chaining the carry between nibbles. It collects the result nibbles and combines the per-nibble flags into whole-word flags. It sits between the control unit and a single ALB instance and owns the ALB's MR/MS/CI/ALB_MI inputs.

## Interface
- NIB, default 4 — operand width in nibbles (legal 1..8); word width W = 4*NIB
- CLK  in  1  — clock, rising edge
- RST  in  1  — synchronous active-high reset
- START  in  1  — request strobe; accepted only when READY=1
- OP  in  2  — operation: 00 sub (A + ~B + CIN), 01 AND, 10 OR, 11 add (A + B + CIN)
- CIN  in  1  — carry into nibble 0 (1 for true subtract, 0 for add without carry)
- A, B  in  W  — operands, sampled on acceptance
- READY  out  1  — sequencer idle, can accept START
- DONE  out  1  — one-cycle pulse: RESULT/flags just updated
- RESULT  out  W  — last completed result
- C_OUT, V_OUT, N_OUT, Z_OUT  out  1 each — whole-word flags of the last completed op
- MR, MS  out  4  — to ALB operand inputs
- CI  out  1  — to ALB carry input
- ALB_MI  out  3  — to ALB function select, always {0, OP_reg}
- F_ALB  in  4; CO, VO, NO, ZO  in  1 each — from ALB (combinational)

## Operation
- States: IDLE, RUN, DONE. READY = (state == IDLE).
- IDLE: on START=1, register A, B, OP, CIN; idx <= 0; carry <= CIN; zacc <= 1; go to RUN. START=0: stay.
- RUN: drive MR = A_reg[4*idx+3:4*idx], MS = B_reg nibble idx, CI = carry, ALB_MI = {0, OP_reg}. At the clock edge:
  - Write F_ALB into work nibble idx.
  - carry <= CO.
  - zacc <= zacc & ZO.
  - idx <= idx + 1.
- RUN, last nibble (idx == NIB-1):
  - RESULT <= work with nibble idx replaced by F_ALB.
  - C_OUT <= CO, V_OUT <= VO, N_OUT <= F_ALB[3], Z_OUT <= zacc & ZO.
  - Go to DONE.
- DONE: DONE=1 for this cycle only. Go to IDLE. START is ignored in DONE.
- START in RUN or DONE is ignored. It is not queued.
- Logic ops still run all NIB cycles. The ALB returns CO=VO=0 for them, so C_OUT=V_OUT=0.
- Outside RUN, MR=MS=0, CI=0, ALB_MI=000.
- RESULT and flags hold until the next completed op. They never change mid-operation.
- idx width is clog2(NIB), minimum 1. idx never exceeds NIB-1.

## Timing
- Reset values:
  - state=IDLE, READY=1, DONE=0
  - RESULT=0, all flags 0
  - MR=MS=0, CI=0, ALB_MI=000
  - idx=0, carry=0, zacc=1
- START accepted at edge t. RUN occupies cycles t+1 .. t+NIB. DONE=1 in cycle t+NIB+1, and RESULT is valid from that cycle. READY=1 again in cycle t+NIB+2.
- Throughput: one op per NIB+2 cycles.
- ALB path is purely combinational within a RUN cycle: MR/MS/CI to F_ALB/CO must meet one CLK period.
- RST during RUN or DONE: return to reset values next edge. No DONE pulse; the previous RESULT is cleared to 0.
- NIB=1: single RUN cycle. DONE at t+2.

## Configuration
- ALB_SEQ_ABORT_EN defined: adds input ABORT (1 bit). ABORT=1 in RUN returns to IDLE at that edge, with:
  - no RESULT/flag update
  - no DONE pulse
  - work register discarded
  - ABORT outside RUN has no effect. ABORT wins over the last-nibble update.
- ALB_SEQ_ABORT_EN undefined: no ABORT port. Every accepted op runs to completion.

## Test plan
- NIB=4, OP=11, CIN=0, A=0x1234, B=0x0FFF, START at t → DONE at t+5, RESULT=0x2233, C=0, V=0, N=0, Z=0.
- OP=11, CIN=0, A=0xFFFF, B=0x0001 → RESULT=0x0000, C=1, Z=1, N=0. Per-cycle CI sequence 0,1,1,1.
- OP=00, CIN=1, A=0x0005, B=0x0007 → RESULT=0xFFFE, C=0 (borrow), N=1, Z=0. ALB_MI=000 during all 4 RUN cycles.
- OP=01, A=0xF0F0, B=0x3C3C → RESULT=0x3030, C=0. Back-to-back OP=10 with the same operands → RESULT=0xFCFC, READY gap exactly 1 DONE cycle.
- START pulsed in cycles t+2 and t+5 of a running op → ignored, exactly one DONE. RST at t+3 → READY=1, RESULT=0, DONE never asserted.
- With ALB_SEQ_ABORT_EN: op A=0x1111+0x2222 completed, then a new add with ABORT at its second RUN cycle → IDLE next cycle, no DONE, RESULT stays 0x3333.
